// File: rtl/sync_delay_pkg.sv
// rtl/sync_delay_pkg.sv - shared state type, default parameters and legal-delay check
// SYNC_DELAY_SHORT_EN widens the legal delay range down to 0.
package sync_delay_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_CH           = 3;
    localparam int DEFAULT_DATA_W       = 8;
    localparam int DEFAULT_MAX_DELAY    = 1024;
    localparam int DEFAULT_DELAY_CYCLES = 500;

    function automatic logic delay_legal(input logic [31:0] d, input logic [31:0] max_d);
`ifdef SYNC_DELAY_SHORT_EN
        return d <= max_d;
`else
        return (d >= 32'd2) && (d <= max_d);
`endif
    endfunction

endpackage

// File: rtl/sync_delay_ram.sv
// rtl/sync_delay_ram.sv - simple dual-port ring storage, registered read, no reset
module sync_delay_ram #(
    parameter int W     = 11,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_100M,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_100M) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - programmable sync/data delay line over a block-RAM ring
// SYNC_DELAY_SHORT_EN adds delays 0 (pass-through) and 1 (single register).
module sync_delay_line
    import sync_delay_pkg::*;
#(
    parameter int CH            = DEFAULT_CH,
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int MAX_DELAY     = DEFAULT_MAX_DELAY,
    parameter int DEFAULT_DELAY = DEFAULT_DELAY_CYCLES
) (
    input  logic                         clk_100M,
    input  logic                         rst_p,
    input  logic [CH-1:0]                in_sync,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [$clog2(MAX_DELAY):0]   delay_cfg,
    input  logic                         cfg_load,
    output logic [CH-1:0]                out_sync,
    output logic [DATA_W-1:0]            out_data,
    output logic                         busy,
    output logic                         cfg_err
);

    localparam int AW = $clog2(MAX_DELAY);
    localparam int DW = AW + 1;
    localparam int RW = CH + DATA_W;

    state_t         state, state_nx;
    logic [DW-1:0]  d_reg, d_nx;
    logic [DW-1:0]  fill_cnt, fill_cnt_nx;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           cfg_err_nx;
    logic           cfg_ok;
    logic [RW-1:0]  in_row, ram_q, out_row;

    assign in_row = {in_sync, in_data};
    assign cfg_ok = delay_legal(32'(delay_cfg), 32'(MAX_DELAY));

    // Reading D-1 behind the write pointer plus the RAM read register gives out(t) = in(t-D).
    assign rd_ptr = wr_ptr - AW'(d_reg - DW'(1));

    sync_delay_ram #(
        .W     (RW),
        .DEPTH (MAX_DELAY),
        .AW    (AW)
    ) u_ram (
        .clk_100M (clk_100M),
        .we       (1'b1),
        .waddr    (wr_ptr),
        .wdata    (in_row),
        .raddr    (rd_ptr),
        .rdata    (ram_q)
    );

    always_comb begin
        state_nx    = state;
        d_nx        = d_reg;
        fill_cnt_nx = fill_cnt;
        cfg_err_nx  = 1'b0;
        if (cfg_load && !cfg_ok) begin
            cfg_err_nx = 1'b1;
        end
        // A legal load always wins, including on the last FILL cycle.
        if (cfg_load && cfg_ok) begin
            d_nx        = delay_cfg;
            fill_cnt_nx = '0;
            state_nx    = ST_FILL;
`ifdef SYNC_DELAY_SHORT_EN
            if (delay_cfg == '0) begin
                state_nx = ST_RUN;
            end
`endif
        end else if (state == ST_FILL) begin
            fill_cnt_nx = fill_cnt + DW'(1);
            if (fill_cnt == d_reg - DW'(1)) begin
                state_nx = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk_100M or posedge rst_p) begin
        if (rst_p) begin
            state    <= ST_FILL;
            d_reg    <= DW'(DEFAULT_DELAY);
            fill_cnt <= '0;
            wr_ptr   <= '0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            d_reg    <= d_nx;
            fill_cnt <= fill_cnt_nx;
            wr_ptr   <= wr_ptr + AW'(1);
            cfg_err  <= cfg_err_nx;
        end
    end

`ifdef SYNC_DELAY_SHORT_EN
    logic [RW-1:0] byp_q;

    always_ff @(posedge clk_100M or posedge rst_p) begin
        if (rst_p) begin
            byp_q <= '0;
        end else begin
            byp_q <= in_row;
        end
    end
`endif

    // Gating on state (async-reset register) clears the outputs the moment rst_p rises.
    always_comb begin
        out_row = '0;
        if (state == ST_RUN) begin
`ifdef SYNC_DELAY_SHORT_EN
            if (d_reg == '0) begin
                out_row = in_row;
            end else if (d_reg == DW'(1)) begin
                out_row = byp_q;
            end else begin
                out_row = ram_q;
            end
`else
            out_row = ram_q;
`endif
        end
    end

    assign {out_sync, out_data} = out_row;
    assign busy = (state == ST_FILL);

endmodule

// File: tb/tb_sync_delay_line.sv
// tb/tb_sync_delay_line.sv - directed self-checking bench for sync_delay_line
module tb_sync_delay_line;

    logic        clk_100M = 1'b0;
    logic        rst_p;
    logic [2:0]  in_sync;
    logic [7:0]  in_data;
    logic [10:0] delay_cfg;
    logic        cfg_load;
    logic [2:0]  out_sync;
    logic [7:0]  out_data;
    logic        busy;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    sync_delay_line dut (
        .clk_100M  (clk_100M),
        .rst_p     (rst_p),
        .in_sync   (in_sync),
        .in_data   (in_data),
        .delay_cfg (delay_cfg),
        .cfg_load  (cfg_load),
        .out_sync  (out_sync),
        .out_data  (out_data),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    always #5 clk_100M = ~clk_100M;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
        $fatal(1, "watchdog");
    end

    // Vectors are {busy, cfg_err, out_sync, out_data}.
    task automatic test_reset();
        rst_p = 1'b1; in_sync = '0; in_data = '0; delay_cfg = '0; cfg_load = 1'b0;
        repeat (3) @(posedge clk_100M);
        @(negedge clk_100M);
        checks++;
        if ({busy, cfg_err, out_sync, out_data} !== {1'b1, 1'b0, 3'b000, 8'h00}) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", {busy, cfg_err, out_sync, out_data}, 13'b1_0_000_00000000);
        end
        @(posedge clk_100M); #1;
        rst_p = 1'b0;
    endtask

    task automatic test_default_pulse();
        logic [12:0] exp;
        for (int c = 0; c <= 520; c++) begin
            in_sync = (c == 10) ? 3'b001 : 3'b000;
            in_data = 8'h00;
            cfg_load = 1'b0;
            @(negedge clk_100M);
            exp = {(c < 500), 1'b0, (c == 510) ? 3'b001 : 3'b000, 8'h00};
            checks++;
            if ({busy, cfg_err, out_sync, out_data} !== exp) begin
                errors++;
                $display("FAIL default_pulse c=%0d got %b exp %b", c, {busy, cfg_err, out_sync, out_data}, exp);
            end
            @(posedge clk_100M); #1;
        end
    endtask

    task automatic test_ramp_d2();
        logic [12:0] exp;
        for (int k = 0; k <= 40; k++) begin
            in_sync = 3'b000;
            in_data = 8'(k);
            cfg_load = (k == 0);
            delay_cfg = 11'd2;
            @(negedge clk_100M);
            if (k >= 1) begin
                exp = (k <= 2) ? {1'b1, 1'b0, 3'b000, 8'h00} : {1'b0, 1'b0, 3'b000, 8'(k - 2)};
                checks++;
                if ({busy, cfg_err, out_sync, out_data} !== exp) begin
                    errors++;
                    $display("FAIL ramp_d2 k=%0d got %b exp %b", k, {busy, cfg_err, out_sync, out_data}, exp);
                end
            end
            @(posedge clk_100M); #1;
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_max_delay();
        logic [12:0] exp;
        logic [10:0] kv, v;
        for (int k = 0; k < 2100; k++) begin
            kv = 11'(k);
            {in_sync, in_data} = kv;
            cfg_load = (k == 0);
            delay_cfg = 11'd1024;
            @(negedge clk_100M);
            if (k >= 1) begin
                v = 11'(k - 1024);
                exp = (k <= 1024) ? 13'b1_0_000_00000000 : {1'b0, 1'b0, v};
                checks++;
                if ({busy, cfg_err, out_sync, out_data} !== exp) begin
                    errors++;
                    $display("FAIL max_delay k=%0d got %b exp %b", k, {busy, cfg_err, out_sync, out_data}, exp);
                end
            end
            @(posedge clk_100M); #1;
        end
        cfg_load = 1'b0;
    endtask

    // Continues the 1024-cycle ramp; illegal loads must not disturb it.
    task automatic test_illegal();
        logic [12:0] exp;
        logic [10:0] kv, v;
        logic        err_exp;
        for (int k = 2100; k < 2200; k++) begin
            kv = 11'(k);
            {in_sync, in_data} = kv;
            cfg_load = (k == 2110) || (k == 2120) || (k == 2130) || (k == 2140);
            delay_cfg = (k == 2110) ? 11'd1025 : (k == 2120) ? 11'd1 : (k == 2130) ? 11'd0 : 11'd2047;
            @(negedge clk_100M);
            v = 11'(k - 1024);
            err_exp = (k == 2111) || (k == 2121) || (k == 2131) || (k == 2141);
            exp = {1'b0, err_exp, v};
            checks++;
            if ({busy, cfg_err, out_sync, out_data} !== exp) begin
                errors++;
                $display("FAIL illegal k=%0d got %b exp %b", k, {busy, cfg_err, out_sync, out_data}, exp);
            end
            @(posedge clk_100M); #1;
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_reload_in_fill();
        logic [12:0] exp;
        for (int k = 0; k <= 24; k++) begin
            in_sync = 3'b000;
            in_data = 8'(k);
            cfg_load = (k == 0) || (k == 6);
            delay_cfg = (k == 0) ? 11'd8 : 11'd4;
            @(negedge clk_100M);
            if (k >= 1) begin
                exp = (k <= 10) ? 13'b1_0_000_00000000 : {1'b0, 1'b0, 3'b000, 8'(k - 4)};
                checks++;
                if ({busy, cfg_err, out_sync, out_data} !== exp) begin
                    errors++;
                    $display("FAIL reload_fill k=%0d got %b exp %b", k, {busy, cfg_err, out_sync, out_data}, exp);
                end
            end
            @(posedge clk_100M); #1;
        end
        cfg_load = 1'b0;
    endtask

    // Same-D reload at k=0, reload on the last FILL cycle at k=4, same-D reload from RUN at k=20.
    task automatic test_final_cycle_reload();
        logic [12:0] exp;
        for (int k = 0; k <= 30; k++) begin
            in_sync = 3'b000;
            in_data = 8'(k + 100);
            cfg_load = (k == 0) || (k == 4) || (k == 20);
            delay_cfg = (k == 0) ? 11'd4 : 11'd3;
            @(negedge clk_100M);
            if (k >= 1) begin
                if (k <= 7 || (k >= 21 && k <= 23))
                    exp = 13'b1_0_000_00000000;
                else
                    exp = {1'b0, 1'b0, 3'b000, 8'(k - 3 + 100)};
                checks++;
                if ({busy, cfg_err, out_sync, out_data} !== exp) begin
                    errors++;
                    $display("FAIL final_reload k=%0d got %b exp %b", k, {busy, cfg_err, out_sync, out_data}, exp);
                end
            end
            @(posedge clk_100M); #1;
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [12:0] exp;
        for (int k = 0; k <= 6; k++) begin
            in_sync = 3'b111;
            in_data = 8'hA5;
            cfg_load = (k == 0);
            delay_cfg = 11'd2;
            @(negedge clk_100M);
            if (k >= 1) begin
                exp = (k <= 2) ? 13'b1_0_000_00000000 : {1'b0, 1'b0, 3'b111, 8'hA5};
                checks++;
                if ({busy, cfg_err, out_sync, out_data} !== exp) begin
                    errors++;
                    $display("FAIL async_pre k=%0d got %b exp %b", k, {busy, cfg_err, out_sync, out_data}, exp);
                end
            end
            if (k < 6) begin
                @(posedge clk_100M); #1;
            end
        end
        cfg_load = 1'b0;
        rst_p = 1'b1;
        #1;
        checks++;
        if ({busy, cfg_err, out_sync, out_data} !== 13'b1_0_000_00000000) begin
            errors++;
            $display("FAIL async_clear got %b exp %b", {busy, cfg_err, out_sync, out_data}, 13'b1_0_000_00000000);
        end
        @(posedge clk_100M);
        @(posedge clk_100M); #1;
        rst_p = 1'b0;
        for (int c = 0; c <= 505; c++) begin
            @(negedge clk_100M);
            exp = (c < 500) ? 13'b1_0_000_00000000 : {1'b0, 1'b0, 3'b111, 8'hA5};
            checks++;
            if ({busy, cfg_err, out_sync, out_data} !== exp) begin
                errors++;
                $display("FAIL async_refill c=%0d got %b exp %b", c, {busy, cfg_err, out_sync, out_data}, exp);
            end
            @(posedge clk_100M); #1;
        end
    endtask

    initial begin
        test_reset();
        test_default_pulse();
        test_ramp_d2();
        test_max_delay();
        test_illegal();
        test_reload_in_fill();
        test_final_cycle_reload();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_delay_line.md
SYNC_DELAY_LINE -- requirements
Module: sync_delay_line

Interface
REQ-001 SHALL have parameter CH, default 3, number of 1-bit sync channels (e.g. clken, href, vsync).
REQ-002 SHALL have parameter DATA_W, default 8, width of the delayed pixel data bus.
REQ-003 SHALL have parameter MAX_DELAY, default 1024, power of two, ring depth and largest legal delay.
REQ-004 SHALL have parameter DEFAULT_DELAY, default 500, delay in force after reset; legal range 2..MAX_DELAY.
REQ-005 SHALL have port clk_100M, input, 1, clock; all logic rising-edge.
REQ-006 SHALL have port rst_p, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port in_sync, input, CH, sync strobes to delay.
REQ-008 SHALL have port in_data, input, DATA_W, data to delay.
REQ-009 SHALL have port delay_cfg, input, $clog2(MAX_DELAY)+1, requested delay in cycles.
REQ-010 SHALL have port cfg_load, input, 1, single-cycle pulse that samples delay_cfg.
REQ-011 SHALL have port out_sync, output, CH, delayed in_sync.
REQ-012 SHALL have port out_data, output, DATA_W, delayed in_data.
REQ-013 SHALL have port busy, output, 1, high while the ring is refilling.
REQ-014 SHALL have port cfg_err, output, 1, one-cycle pulse on a rejected cfg_load.

Function
REQ-015 SHALL write {in_sync,in_data} every cycle at wr_ptr, with wr_ptr incrementing modulo MAX_DELAY and no wait states.
REQ-016 SHALL read at wr_ptr-(D-1) modulo MAX_DELAY into a registered output, so that out(t)=in(t-D) for active delay D.
REQ-017 SHALL implement two states: FILL (outputs gated, busy=1) and RUN (outputs = ring data, busy=0).
REQ-018 SHALL count fill cycles in FILL and move to RUN once D cycles have elapsed since entry.
REQ-019 SHALL, in FILL, drive out_sync and out_data to all-zero, since ring contents are unreset or stale.
REQ-020 SHALL, on cfg_load at cycle t with legal delay_cfg, make the new D effective at t+1, enter FILL, and clear the fill counter.
REQ-021 SHALL then hold outputs zero for cycles t+1..t+D, with the first valid output in(t+1) appearing at t+D+1.
REQ-022 SHALL restart the fill counter from zero on a legal cfg_load during FILL.
REQ-023 SHALL, on a cfg_load during the final FILL cycle, have the reload win and keep state FILL.
REQ-024 SHALL treat delay_cfg outside 2..MAX_DELAY as illegal: pulse cfg_err at t+1, ignore the load, and leave D, state and outputs untouched.
REQ-025 SHALL treat a cfg_load with delay_cfg equal to the current D as legal and re-enter FILL.
REQ-026 SHALL ignore simultaneous in_sync activity during a reconfiguration; it is neither buffered nor reordered.

Reset
REQ-027 SHALL, while rst_p is high, clear wr_ptr, fill counter, out_sync, out_data and cfg_err, set busy=1, state FILL and D=DEFAULT_DELAY.
REQ-028 SHALL not reset the ring storage.
REQ-029 SHALL, after reset release, hold outputs zero for the first DEFAULT_DELAY cycles.
REQ-030 SHALL, on rst_p asserted mid-RUN, clear outputs immediately (asynchronously).

Configuration
REQ-031 SHALL support macro SYNC_DELAY_SHORT_EN; when defined, D=0 is legal: combinational pass-through, busy=0, no FILL.
REQ-032 SHALL, with SYNC_DELAY_SHORT_EN defined, treat D=1 as legal via a dedicated output register, with FILL lasting 1 cycle.
REQ-033 SHALL, without SYNC_DELAY_SHORT_EN, reject D=0 and D=1 per REQ-024, with no bypass logic present.

Structure
REQ-034 SHALL place the state enum (FILL, RUN), the DEFAULT_* parameter constants and the legal-range check function in shared package sync_delay_pkg.
REQ-035 SHALL use one sub-module, sync_delay_ram: simple dual-port, width CH+DATA_W, depth MAX_DELAY, registered read, no reset, inferable as block RAM.

Verification
REQ-036 SHALL cover: reset then single in_sync[0] pulse at cycle 10, default config -> out_sync[0] pulse at cycle 510 only; busy low from cycle 500.
REQ-037 SHALL cover: incrementing in_data 0,1,2,... with cfg_load delay_cfg=2 -> after refill, out_data equals in_data two cycles earlier every cycle.
REQ-038 SHALL cover: cfg_load delay_cfg=1024 (MAX) then 2048-cycle ramp -> exact 1024-cycle lag across wr_ptr wrap, no glitch at the wrap.
REQ-039 SHALL cover: cfg_load delay_cfg=1025, and delay_cfg=1 without the macro -> cfg_err pulse, D unchanged, outputs continue uninterrupted.
REQ-040 SHALL cover: cfg_load delay_cfg=8, then a second load delay_cfg=4 at FILL cycle 6 -> busy stays high, outputs zero until 4 cycles after the second load.
REQ-041 SHALL cover: rst_p asserted mid-RUN while out_sync=3'b111 -> outputs zero asynchronously, DEFAULT_DELAY refill after release.
